// File: rtl/secure_bank_pkg.sv
// secure_bank_pkg
// Shared definitions for secure_register_bank:
//   state_t     - controller state encoding
//   DEF_*       - default parameter values
//   cnt_width() - bits needed for a counter that runs 0 .. max_count-1
package secure_bank_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      WAIT_CONFIRM = 3'd1,
      WRITE        = 3'd2,
      DENY         = 3'd3,
      LOCKOUT      = 3'd4
   } state_t;

   localparam int DEF_NUM_CH          = 4;
   localparam int DEF_DATA_W          = 4;
   localparam int DEF_PASS_W          = 4;
   localparam int DEF_CONFIRM_TIMEOUT = 8;
   localparam int DEF_MAX_TRIES       = 3;
   localparam int DEF_LOCKOUT_CYCLES  = 16;

   function automatic int cnt_width(input int max_count);
      return (max_count < 2) ? 1 : $clog2(max_count);
   endfunction

endpackage

// File: rtl/channel_register.sv
// channel_register
// One storage channel: DATA_W-bit register loaded when en is high,
// cleared asynchronously by reset (active low).
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low clear
//   en    - load enable
//   d     - load data
//   q     - stored value
module channel_register #(
   parameter int DATA_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              en,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] q
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)  q <= '0;
      else if (en) q <= d;
   end

endmodule

// File: rtl/secure_register_bank.sv
// secure_register_bank
// Password-gated bank of NUM_CH registers. A request latches a channel and
// data; a following confirm with the matching password writes that channel.
// Wrong password, out-of-range channel or confirm timeout deny the write.
// Optional feature macro: LOCKOUT_EN (brute-force lockout after MAX_TRIES
// consecutive denials, lasting LOCKOUT_CYCLES cycles).
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   system_password       - reference password
//   request/ch_sel/input_data - start an operation (sampled in IDLE only)
//   confirm/input_password    - password presentation (WAIT_CONFIRM only)
//   qout                  - all channels, channel i at [i*DATA_W +: DATA_W]
//   busy/granted/denied/locked - status; granted/denied are 1-cycle pulses
//   dbg_state             - current controller state
// Handshake: request and confirm are level strobes with no ready; each is
// consumed on the single edge where the controller is in the state that
// accepts it, and ignored in every other state.
module secure_register_bank
   import secure_bank_pkg::*;
#(
   parameter int NUM_CH          = DEF_NUM_CH,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int PASS_W          = DEF_PASS_W,
   parameter int CONFIRM_TIMEOUT = DEF_CONFIRM_TIMEOUT,
   parameter int MAX_TRIES       = DEF_MAX_TRIES,
   parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES,
   localparam int SEL_W          = (NUM_CH < 2) ? 1 : $clog2(NUM_CH)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [PASS_W-1:0]        system_password,
   input  logic                     request,
   input  logic [SEL_W-1:0]         ch_sel,
   input  logic [DATA_W-1:0]        input_data,
   input  logic                     confirm,
   input  logic [PASS_W-1:0]        input_password,
   output logic [NUM_CH*DATA_W-1:0] qout,
   output logic                     busy,
   output logic                     granted,
   output logic                     denied,
   output logic                     locked,
   output logic [2:0]               dbg_state
);

   // One counter serves both the confirm timeout and the lockout period;
   // it is sized for the largest bound so both builds share one width.
   localparam int CNT_MAX0 = (CONFIRM_TIMEOUT > LOCKOUT_CYCLES) ? CONFIRM_TIMEOUT : LOCKOUT_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX0 > MAX_TRIES) ? CNT_MAX0 : MAX_TRIES;
   localparam int CNT_W    = cnt_width(CNT_MAX);

   state_t              state, next_state;
   logic [CNT_W-1:0]    cnt;
   logic [SEL_W-1:0]    lat_ch;
   logic [DATA_W-1:0]   lat_data;
   logic                pass_ok;

   // Out-of-range channels (non-power-of-two NUM_CH) can never be granted.
   assign pass_ok = (input_password == system_password) &&
                    ({1'b0, lat_ch} < (SEL_W+1)'(NUM_CH));

`ifdef LOCKOUT_EN
   localparam int FAIL_W = cnt_width(MAX_TRIES + 1);
   logic [FAIL_W-1:0] fail_cnt;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (request) next_state = WAIT_CONFIRM;
         end
         WAIT_CONFIRM: begin
            // A confirm on the last allowed cycle still wins over timeout.
            if (confirm)                                  next_state = pass_ok ? WRITE : DENY;
            else if (cnt == CNT_W'(CONFIRM_TIMEOUT - 1))  next_state = DENY;
         end
         WRITE: next_state = IDLE;
         DENY: begin
`ifdef LOCKOUT_EN
            next_state = (fail_cnt == FAIL_W'(MAX_TRIES - 1)) ? LOCKOUT : IDLE;
`else
            next_state = IDLE;
`endif
         end
         LOCKOUT: begin
            if (cnt == CNT_W'(LOCKOUT_CYCLES - 1)) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy      = (state != IDLE);
      granted   = (state == WRITE);
      denied    = (state == DENY);
`ifdef LOCKOUT_EN
      locked    = (state == LOCKOUT);
`else
      locked    = 1'b0;
`endif
      dbg_state = state;
   end

   // Datapath: operation latch and the shared cycle counter, which restarts
   // on every state change so it always counts cycles spent in this state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt      <= '0;
         lat_ch   <= '0;
         lat_data <= '0;
      end else begin
         if (state != next_state)                           cnt <= '0;
         else if (state == WAIT_CONFIRM || state == LOCKOUT) cnt <= cnt + CNT_W'(1);
         if (state == IDLE && request) begin
            lat_ch   <= ch_sel;
            lat_data <= input_data;
         end
      end
   end

`ifdef LOCKOUT_EN
   // Consecutive-denial count; any grant or completed lockout clears it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                     fail_cnt <= '0;
      else if (state == WRITE)                        fail_cnt <= '0;
      else if (state == DENY)                         fail_cnt <= fail_cnt + FAIL_W'(1);
      else if (state == LOCKOUT && next_state == IDLE) fail_cnt <= '0;
   end
`endif

   // Channel storage
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic we;
      assign we = (state == WRITE) && (lat_ch == SEL_W'(i));
      channel_register #(.DATA_W(DATA_W)) u_reg (
         .clock (clock),
         .reset (reset),
         .en    (we),
         .d     (lat_data),
         .q     (qout[i*DATA_W +: DATA_W])
      );
   end

endmodule
